// File: rtl/uart_top_rx.sv
// uart_top_rx: UART receiver with input synchroniser, mid-bit sampling FSM,
// optional even parity, 1/2 stop bits, show-ahead receive FIFO and sticky error flags.
module uart_top_rx #(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic        parity_sel,
  input  logic        stop_sel,
  input  logic [11:0] baud_divisor,
  input  logic        rd_en,
  input  logic        err_clr,
  output logic [31:0] data_out,
  output logic        rxfe,
  output logic        rxff,
  output logic        parity_err,
  output logic        frame_err,
  output logic        overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2, PUSH
  } state_t;

  state_t state, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [11:0]            bc;
  logic [11:0]            div_q;
  logic [11:0]            half;
  logic                   par_q;
  logic                   stop_q;
  logic [2:0]             idx;
  logic [7:0]             shreg;
  logic                   sample;
  logic                   push_en;
  logic                   par_set;
  logic                   frm_set;
  logic                   ovr_set;
  logic                   pop;
  logic [7:0]             mem [FIFO_DEPTH];
  logic [AW:0]            wr_ptr;
  logic [AW:0]            rd_ptr;

  // rx is asynchronous to clk; only the last synchroniser stage feeds the FSM
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

  assign rx_s   = sync_q[SYNC_STAGES-1];
  assign half   = div_q >> 1;
  assign sample = (state == START) ? (bc == half - 12'd1) : (bc == div_q - 12'd1);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    push_en = 1'b0;
    par_set = 1'b0;
    frm_set = 1'b0;
    ovr_set = 1'b0;
    case (state)
      IDLE:   if (!rx_s) state_d = START;
      START:  if (sample) state_d = rx_s ? IDLE : DATA;
      DATA:   if (sample && idx == 3'd7) state_d = par_q ? PARITY : STOP1;
      PARITY: if (sample) begin
                par_set = (^shreg) ^ rx_s;
                state_d = STOP1;
              end
      STOP1:  if (sample) begin
                frm_set = !rx_s;
                state_d = stop_q ? STOP2 : PUSH;
              end
      STOP2:  if (sample) begin
                frm_set = !rx_s;
                state_d = PUSH;
              end
      PUSH:   begin
                state_d = IDLE;
                if (rxff && !rd_en) ovr_set = 1'b1;
                else                push_en = 1'b1;
              end
      default: state_d = IDLE;
    endcase
  end

  // Frame configuration is captured at start detection so mid-frame changes have no effect
  always_ff @(posedge clk) begin
    if (reset) begin
      bc     <= '0;
      idx    <= '0;
      shreg  <= '0;
      div_q  <= '0;
      par_q  <= 1'b0;
      stop_q <= 1'b0;
    end else begin
      if (state == IDLE) begin
        bc  <= '0;
        idx <= '0;
        if (!rx_s) begin
          div_q  <= baud_divisor;
          par_q  <= parity_sel;
          stop_q <= stop_sel;
        end
      end else if (state == PUSH || sample) begin
        bc <= '0;
      end else begin
        bc <= bc + 12'd1;
      end
      if (state == DATA && sample) begin
        shreg <= {rx_s, shreg[7:1]};
        idx   <= idx + 3'd1;
      end
    end
  end

  assign pop  = rd_en && !rxfe;
  assign rxfe = (wr_ptr == rd_ptr);
  assign rxff = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign data_out = rxfe ? 32'h0 : {24'h0, mem[rd_ptr[AW-1:0]]};

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr[AW-1:0]] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // A new error in the same cycle as err_clr keeps its flag set
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      parity_err <= par_set | (parity_err & ~err_clr);
      frame_err  <= frm_set | (frame_err  & ~err_clr);
      overrun    <= ovr_set | (overrun    & ~err_clr);
    end
  end

endmodule
